alu_addsub_pipe: RTL and testbench
==================================

Name: alu_addsub_pipe

Overview:
- Two-stage pipelined add/subtract execution stage wrapped around the team's combinational 32-bit adder.
- Accepts operand pairs and an opcode over a valid/ready handshake, and forms the effective B operand and carry-in.
- Computes sum and flags in stage 2 and presents a registered result downstream.
- Holds an architectural carry flag so ADC/SBC chain multi-word arithmetic across back-to-back operations.

Parameters:
- WIDTH, 32, operand/result width; only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  stage can accept
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  sum/difference
- out_flags  output  4  {N,Z,C,V}
- carry_q  output  1  current architectural carry flag

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - both stage valid bits, out_valid, out_result, out_flags and carry_q to 0;
  - in-flight operations, which are discarded with no partial output.
- in_ready=1 during reset.
- Stage 1 (S1) registers a, b and op on an accept (in_valid & in_ready).
- Stage 2 (S2) is loaded by the S1→S2 transfer. On that transfer:
  - Effective B: ADD/ADC use b; SUB/SBC use ~b.
  - Carry-in: ADD=0, SUB=1, ADC/SBC=carry_q.
  - {cout,sum} = a + b_eff + cin, formed by the adder sub-module; sum is truncated to WIDTH.
  - Flags: N=sum[WIDTH-1]; Z=(sum==0); C=cout; V=(a[MSB]==b_eff[MSB]) & (sum[MSB]!=a[MSB]).
  - carry_q<=cout on the same edge, for every op type.
- Carry convention for subtract: C=1 means no borrow.
- Ordering and carry hazard: transfers are strictly in order. The next op's S1→S2 transfer happens at least one edge later and sees the updated carry_q, so no hazard logic is needed.
- Latency is 2 cycles from accept to out_valid with no backpressure. Throughput is 1 op/cycle.
- Handshake:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | s2_advance.
  - in_ready = !s1_valid | s2_advance. This is a full-throughput chain; in_ready depends combinationally on out_ready.
  - out_valid=s2_valid.
- While out_valid=1 & out_ready=0: out_result, out_flags and carry_q hold stable and no new transfer occurs.
- When S2 empties with no new data: out_valid drops. out_result/out_flags keep their last value; nothing is required beyond that.
- Simultaneous accept and output on one edge: both happen, and occupancy is unchanged.
- When full (s1_valid & s2_valid & !out_ready): in_ready=0, and in_a/in_b/in_op are ignored.
- Wrap-around: 0xFFFFFFFF + 1 gives sum=0 and C=1. There is no saturation.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10, OP_SBC=2'b11;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module: add_core32, a combinational WIDTH-bit adder with cin producing sum and cout, instantiated between S1 and S2.
- Handshake and flag logic stay in the top module.

Test Plan:
- ADD with a=0x7FFFFFFF, b=1, out_ready=1 -> 2 cycles later result=0x80000000, flags N=1 Z=0 C=0 V=1.
- SUB with a=5, b=5 -> result=0, Z=1, C=1, V=0; SUB with a=0, b=1 -> result=0xFFFFFFFF, N=1, C=0.
- 64-bit chain: ADD 0xFFFFFFFF+0x00000001 then ADC 0x00000000+0x00000000 issued back-to-back -> results 0x00000000 (C=1), then 0x00000001 (C=0). Repeat with SUB/SBC for 0x1_00000000-1 -> 0xFFFFFFFF, 0x00000000.
- Backpressure: stream 4 ADDs while holding out_ready=0 -> in_ready falls after 2 accepts and out_result stays stable. Release out_ready -> all 4 results arrive in order with no loss or duplication.
- Reset mid-stream with both stages full and carry_q=1 -> next cycle out_valid=0, carry_q=0, in_ready=1. A subsequent ADC 1+1 yields 2.
- Random back-to-back ops with random out_ready, checked against a reference model of result, flags and carry_q -> zero mismatches over 10k ops.

Source files
------------

// File: rtl/alu_addsub_pipe_pkg.sv
// alu_addsub_pipe_pkg: opcode and flag-index constants shared by the add/sub pipeline
package alu_addsub_pipe_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/add_core32.sv
// add_core32: combinational WIDTH-bit adder with carry-in and carry-out
module add_core32
  import alu_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: two-stage add/subtract stage with NZCV flags and an architectural carry for ADC/SBC chains
module alu_addsub_pipe
  import alu_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             carry_q
);
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [1:0]       r_s1_op;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_carry;
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_cin;
  logic             w_cout;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic [3:0]       w_flags;

  assign w_s2_adv   = !r_s2_valid | out_ready;
  assign w_s1_adv   = !r_s1_valid | w_s2_adv;
  assign in_ready   = rst | w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign out_result = r_result;
  assign out_flags  = r_flags;
  assign carry_q    = r_carry;

  // Effective B operand and carry-in; ADC/SBC pull in the architectural carry
  always_comb begin
    w_b_eff = (r_s1_op == OP_ADD || r_s1_op == OP_ADC) ? r_s1_b : ~r_s1_b;
    w_cin   = (r_s1_op == OP_ADC || r_s1_op == OP_SBC) ? r_carry : (r_s1_op == OP_SUB);
  end

  add_core32 #(.WIDTH(WIDTH)) u_add (
    .a    (r_s1_a),
    .b    (w_b_eff),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // NZCV from the adder result; V compares signs of the actual adder inputs
  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_sum[WIDTH-1];
    w_flags[FLAG_Z] = (w_sum == '0);
    w_flags[FLAG_C] = w_cout;
    w_flags[FLAG_V] = (r_s1_a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
  end

  // Stage 1: capture operands on accept; empties when its op moves on with nothing new behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_op <= in_op;
      end
    end
  end

  // Stage 2: register result, flags and carry together so a chained op one edge later sees the new carry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_carry    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_sum;
        r_flags  <= w_flags;
        r_carry  <= w_cout;
      end
    end
  end
endmodule

// File: tb/tb_alu_addsub_pipe.sv
// tb_alu_addsub_pipe: scoreboard bench for the add/sub pipeline with directed vectors and a reference model
module tb_alu_addsub_pipe;
  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
    logic        c;
  } exp_t;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        carry_q;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic mc = 1'b0;
  logic rnd = 1'b0;

  alu_addsub_pipe #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .carry_q    (carry_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference: plain signed/unsigned 64-bit arithmetic, borrow form for subtraction
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic c);
    exp_t   e;
    longint ua, ub, sa, sb, full, sfull;
    logic   cin, bor;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cin = (op == 2'b10) ? c : 1'b0;
    bor = (op == 2'b11) ? !c : 1'b0;
    if (!op[0]) begin
      full  = ua + ub + longint'(cin);
      sfull = sa + sb + longint'(cin);
      e.c   = full[32];
    end else begin
      full  = ua - ub - longint'(bor);
      sfull = sa - sb - longint'(bor);
      e.c   = (ua >= ub + longint'(bor));
    end
    e.r = full[31:0];
    e.f = {e.r[31], e.r == 32'h0, e.c, (sfull > SMAX) || (sfull < SMIN)};
    return e;
  endfunction

  // Offer one op, wait (bounded) for acceptance, record expectation at the accepting edge
  task automatic send_e(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input exp_t e);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at 0 expected 1");
      return;
    end
    q.push_back(e);
    mc = e.c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [31:0] er, input logic [3:0] ef);
    exp_t e;
    e.r = er;
    e.f = ef;
    e.c = ef[1];
    send_e(a, b, op, e);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every completed output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got result 0x%08h expected no output", out_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", out_result, e.r);
        chk("flags", {28'h0, out_flags}, {28'h0, e.f});
        chk("carry_q", {31'h0, carry_q}, {31'h0, e.c});
      end
    end
  end

  initial begin
    logic [31:0] r0;
    @(negedge clk);
    chk("in_ready_in_reset", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_carry", {31'h0, carry_q}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {28'h0, out_flags}, 32'd0);
    @(posedge clk);
    #1;

    send(32'h7FFFFFFF, 32'h1, 2'b00, 32'h80000000, 4'b1001);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_1edge", {31'h0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_2edge", {31'h0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    send(32'd5, 32'd5, 2'b01, 32'h0, 4'b0110);
    send(32'd0, 32'd1, 2'b01, 32'hFFFFFFFF, 4'b1000);
    send(32'hFFFFFFFF, 32'h1, 2'b00, 32'h0, 4'b0110);
    send(32'h0, 32'h0, 2'b10, 32'h1, 4'b0000);
    send(32'h0, 32'h1, 2'b01, 32'hFFFFFFFF, 4'b1000);
    send(32'h1, 32'h0, 2'b11, 32'h0, 4'b0110);
    idle(4);

    out_ready = 1'b0;
    send(32'd1, 32'd2, 2'b00, 32'd3, 4'b0000);
    send(32'd10, 32'd20, 2'b00, 32'd30, 4'b0000);
    in_valid = 1'b1;
    in_a     = 32'hFFFFFFFF;
    in_b     = 32'hFFFFFFFF;
    in_op    = 2'b00;
    @(negedge clk);
    chk("full_in_ready", {31'h0, in_ready}, 32'd0);
    chk("stall_valid", {31'h0, out_valid}, 32'd1);
    r0 = out_result;
    chk("stall_head", r0, 32'd3);
    repeat (3) @(negedge clk);
    chk("stall_stable", out_result, r0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 4'b1010);
    send(32'h40000000, 32'h40000000, 2'b00, 32'h80000000, 4'b1001);
    idle(5);

    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h1, 2'b00, 32'h0, 4'b0110);
    send(32'h1, 32'h1, 2'b00, 32'h2, 4'b0000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_carry", {31'h0, carry_q}, 32'd1);
    chk("pre_rst_full", {31'h0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mc = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'h0, out_valid}, 32'd0);
    chk("post_rst_carry", {31'h0, carry_q}, 32'd0);
    chk("post_rst_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(32'h1, 32'h1, 2'b10, 32'h2, 4'b0000);
    idle(4);

    rnd = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a, b;
      logic [1:0]  op;
      a  = rnd32();
      b  = rnd32();
      op = 2'($urandom_range(0, 3));
      send_e(a, b, op, model(a, b, op, mc));
    end
    rnd = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
